instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Multi-cycle instruction fetch stage sitting directly upstream of the immediate extender and decode logic.
- Owns the PC and issues one request at a time to instruction memory over a req/gnt/rvalid interface.
- Captures each returned word into an instruction register and presents it with a valid/ready handshake.
- Downstream (extend/decode/execute) consumes it, and supplies branch/jump redirects back.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- Imem_req_out  out  1  fetch request to instruction memory
- Imem_addr_out  out  XLEN  fetch address; always equals the current PC
- Imem_gnt_in  in  1  memory accepted request this cycle
- Imem_rvalid_in  in  1  read data valid
- Imem_rdata_in  in  XLEN  read data
- Instr_out  out  XLEN  registered instruction word to extend/decode
- Instr_pc_out  out  XLEN  PC of Instr_out
- Instr_valid_out  out  1  Instr_out holds an unconsumed instruction
- Instr_ready_in  in  1  downstream consumes Instr_out this cycle
- Redirect_in  in  1  branch/jump taken; load new PC
- Redirect_pc_in  in  XLEN  redirect target
- Misalign_out  out  1  sticky fault: redirect target[1:0] != 0

Behaviour:
- Reset values:
  - Imem_req_out = 0, PC = RESET_PC, Instr_out = 32'h0000_0013 (NOP), Instr_pc_out = 0.
  - Instr_valid_out = 0, Misalign_out = 0, state = IDLE.
- States: IDLE, REQ, WAIT, HOLD, DRAIN, FAULT.
- IDLE: one cycle after reset, then REQ.
- REQ: Imem_req_out = 1.
  - On Imem_gnt_in, go to WAIT.
  - Imem_req_out is 0 in every other state.
- WAIT: on Imem_rvalid_in:
  - Instr_out <= Imem_rdata_in, Instr_pc_out <= PC, Instr_valid_out <= 1, go to HOLD.
  - Imem_rvalid_in is ignored outside WAIT/DRAIN.
  - It is never accepted in the same cycle as the gnt.
- HOLD: on Instr_ready_in:
  - PC <= PC + 4 (modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0).
  - Instr_valid_out <= 0, go to REQ.
  - Instr_out and Instr_pc_out are held stable while valid and not ready.
- Minimum latency: gnt in cycle t, rvalid in t+1, Instr_valid_out high in t+2.
  - Back-to-back throughput is therefore one instruction per 3 cycles minimum.
- Redirect (aligned target) has priority over every other event in the same cycle. PC <= Redirect_pc_in and Instr_valid_out <= 0, then by state:
  - IDLE/REQ without gnt: go to REQ.
  - REQ with gnt in the same cycle: the granted request is at the old address, so go to DRAIN.
  - WAIT: go to DRAIN.
    - If rvalid arrives in the same cycle, discard the data and go to REQ.
  - HOLD: go to REQ. A simultaneous Instr_ready_in is ignored, with no PC+4.
  - DRAIN: wait for Imem_rvalid_in, discard the data, go to REQ.
    - A further redirect in DRAIN updates PC and stays in DRAIN.
- Imem_addr_out may change while Imem_req_out is high (redirect in REQ). Memory samples the address only in the gnt cycle.
- Misaligned redirect (Redirect_pc_in[1:0] != 0):
  - PC <= target, Misalign_out <= 1 (sticky), Instr_valid_out <= 0, go to FAULT.
  - FAULT: no requests, all further inputs ignored, exit only by rst.
  - An outstanding response arriving in FAULT is discarded.
- rst mid-operation: returns to reset values next edge regardless of state.
  - Any response for the abandoned request that arrives in IDLE/REQ is ignored.
- At most one request is outstanding at any time.

Decomposition:
- Shared package:
  - state encoding for IDLE/REQ/WAIT/HOLD/DRAIN/FAULT;
  - NOP_INSTR = 32'h0000_0013;
  - PC_INC = 4.
- One natural sub-module: fetch_ir. It is the instruction/PC capture register with load and clear enables, and it holds the NOP reset value.
- The FSM and PC register stay in instr_fetch.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, memory grants immediately, rvalid one cycle later with 0x00500093, ready held high.
  - Required: Instr_out = 0x00500093 with Instr_pc_out = 0, then the next request at addr 0x4; valid asserted every 3 cycles.
- Backpressure:
  - Stimulus: Instr_ready_in low for 5 cycles in HOLD.
  - Required: Instr_out/Instr_pc_out stable, Imem_req_out = 0, PC unchanged, then exactly one PC+4 on release.
- Redirect in WAIT:
  - Stimulus: redirect to 0x100 while waiting; stale rvalid returns 0xDEADBEEF.
  - Required: the stale word is never presented; the next request is at addr 0x100.
- Redirect in HOLD with simultaneous ready:
  - Stimulus: PC = 0x8, redirect to 0x40 plus ready.
  - Required: the next request is at 0x40, not 0xC.
- Misaligned redirect:
  - Stimulus: redirect to 0x102.
  - Required: Misalign_out = 1 next cycle and stays high; Imem_req_out stays 0 until rst.
- Wrap and reset:
  - Stimulus: RESET_PC = 0xFFFFFFFC, one handshake.
  - Required: next addr = 0x0.
  - Stimulus: rst asserted mid-WAIT.
  - Required: all outputs return to reset values next edge.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM states
//   NOP_INSTR     : instruction presented before anything has been fetched
//   PC_INC        : sequential PC step in bytes
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/instr_fetch_ir.sv
// Instruction register with its PC tag and valid flag.
//   clk, rst       : clock, synchronous active-high reset
//   load           : capture instr_d/pc_d and mark valid
//   clear          : drop valid; instruction and PC are held
//   instr_d, pc_d  : word and address to capture
//   instr_q, pc_q  : registered word and address (reset to NOP / 0)
//   valid_q        : register holds an unconsumed instruction
module fetch_ir
    import instr_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] instr_q,
    output logic [XLEN-1:0] pc_q,
    output logic            valid_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= XLEN'(NOP_INSTR);
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch stage: owns the PC, issues one request at a
// time over req/gnt/rvalid and presents each returned word downstream with a
// valid/ready handshake. Branch/jump redirects reload the PC; a misaligned
// target parks the stage in FAULT until reset.
//   clk, rst                    : clock, synchronous active-high reset
//   Imem_req_out/addr_out       : request and address (address == PC)
//   Imem_gnt_in                 : request accepted this cycle
//   Imem_rvalid_in/rdata_in     : read response
//   Instr_out/pc_out/valid_out  : captured instruction, its PC, valid
//   Instr_ready_in              : downstream consumes Instr_out
//   Redirect_in/pc_in           : taken branch/jump and its target
//   Misalign_out                : sticky misaligned-redirect fault
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            Imem_req_out,
    output logic [XLEN-1:0] Imem_addr_out,
    input  logic            Imem_gnt_in,
    input  logic            Imem_rvalid_in,
    input  logic [XLEN-1:0] Imem_rdata_in,
    output logic [XLEN-1:0] Instr_out,
    output logic [XLEN-1:0] Instr_pc_out,
    output logic            Instr_valid_out,
    input  logic            Instr_ready_in,
    input  logic            Redirect_in,
    input  logic [XLEN-1:0] Redirect_pc_in,
    output logic            Misalign_out
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            misalign;
    logic            redir_ok;
    logic            redir_bad;
    logic            ir_load;
    logic            ir_clear;

    always_comb begin
        redir_ok  = Redirect_in && (Redirect_pc_in[1:0] == 2'b00);
        redir_bad = Redirect_in && (Redirect_pc_in[1:0] != 2'b00);
        // Any redirect suppresses capture of the word returning in WAIT.
        ir_load   = (state == ST_WAIT) && Imem_rvalid_in && !Redirect_in;
        ir_clear  = (state != ST_FAULT) &&
                    (Redirect_in || ((state == ST_HOLD) && Instr_ready_in));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= XLEN'(RESET_PC);
            misalign <= 1'b0;
        end else if (state != ST_FAULT) begin
            if (redir_bad) begin
                pc       <= Redirect_pc_in;
                misalign <= 1'b1;
                state    <= ST_FAULT;
            end else if (redir_ok) begin
                pc <= Redirect_pc_in;
                case (state)
                    // A grant in the redirect cycle was for the old address.
                    ST_REQ:   state <= Imem_gnt_in ? ST_DRAIN : ST_REQ;
                    // If the outstanding response lands in the redirect cycle
                    // it is discarded here and nothing remains to drain.
                    ST_WAIT,
                    ST_DRAIN: state <= Imem_rvalid_in ? ST_REQ : ST_DRAIN;
                    default:  state <= ST_REQ;
                endcase
            end else begin
                case (state)
                    ST_IDLE:  state <= ST_REQ;
                    ST_REQ:   if (Imem_gnt_in) state <= ST_WAIT;
                    ST_WAIT:  if (Imem_rvalid_in) state <= ST_HOLD;
                    ST_HOLD: begin
                        if (Instr_ready_in) begin
                            pc    <= pc + XLEN'(PC_INC);
                            state <= ST_REQ;
                        end
                    end
                    ST_DRAIN: if (Imem_rvalid_in) state <= ST_REQ;
                    default:  state <= ST_FAULT;
                endcase
            end
        end
    end

    assign Imem_req_out  = (state == ST_REQ);
    assign Imem_addr_out = pc;
    assign Misalign_out  = misalign;

    fetch_ir #(
        .XLEN(XLEN)
    ) u_ir (
        .clk     (clk),
        .rst     (rst),
        .load    (ir_load),
        .clear   (ir_clear),
        .instr_d (Imem_rdata_in),
        .pc_d    (pc),
        .instr_q (Instr_out),
        .pc_q    (Instr_pc_out),
        .valid_q (Instr_valid_out)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch. Each vector applies inputs,
// takes one rising edge and compares all outputs 1 ns later. A second
// instance with RESET_PC = 0xFFFF_FFFC exercises PC wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, gnt, rvalid, ready, redir, valid, mis;
    logic [31:0] addr, rdata, instr, ipc, rpc;

    logic        w_req, w_gnt, w_rvalid, w_ready, w_redir, w_valid, w_mis;
    logic [31:0] w_addr, w_rdata, w_instr, w_ipc, w_rpc;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .XLEN    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Imem_req_out   (req),
        .Imem_addr_out  (addr),
        .Imem_gnt_in    (gnt),
        .Imem_rvalid_in (rvalid),
        .Imem_rdata_in  (rdata),
        .Instr_out      (instr),
        .Instr_pc_out   (ipc),
        .Instr_valid_out(valid),
        .Instr_ready_in (ready),
        .Redirect_in    (redir),
        .Redirect_pc_in (rpc),
        .Misalign_out   (mis)
    );

    instr_fetch #(
        .RESET_PC(32'hFFFF_FFFC),
        .XLEN    (32)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .Imem_req_out   (w_req),
        .Imem_addr_out  (w_addr),
        .Imem_gnt_in    (w_gnt),
        .Imem_rvalid_in (w_rvalid),
        .Imem_rdata_in  (w_rdata),
        .Instr_out      (w_instr),
        .Instr_pc_out   (w_ipc),
        .Instr_valid_out(w_valid),
        .Instr_ready_in (w_ready),
        .Redirect_in    (w_redir),
        .Redirect_pc_in (w_rpc),
        .Misalign_out   (w_mis)
    );

    typedef struct {
        logic        rst, gnt, rvalid, ready, redir;
        logic [31:0] rdata, rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, g, v, input logic [31:0] d,
                       input logic rd, rr, input logic [31:0] rp,
                       input logic eq, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ei, ep,
                       input logic em);
        vec_t t;
        t.rst = r; t.gnt = g; t.rvalid = v; t.rdata = d; t.ready = rd;
        t.redir = rr; t.rpc = rp; t.e_req = eq; t.e_addr = ea;
        t.e_valid = ev; t.e_instr = ei; t.e_pc = ep; t.e_mis = em;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        ready = 1'b0; redir = 1'b0; rpc = '0;
        w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
        w_ready = 1'b0; w_redir = 1'b0; w_rpc = '0;

        //   rst gnt rv rdata         rdy rdr rpc           req addr          val instr         ipc           mis
        // reset and sequential fetch with ready held high
        add(1, 0, 0, 32'h0,         0, 0, 32'h0,      0, 32'h0,      0, NOP,           32'h0,      0);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,      1, 32'h0,      0, NOP,           32'h0,      0);
        add(0, 1, 0, 32'h0,         1, 0, 32'h0,      0, 32'h0,      0, NOP,           32'h0,      0);
        add(0, 0, 1, 32'h00500093,  1, 0, 32'h0,      0, 32'h0,      1, 32'h00500093,  32'h0,      0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,      1, 32'h4,      0, 32'h00500093,  32'h0,      0);
        add(0, 1, 0, 32'h0,         1, 0, 32'h0,      0, 32'h4,      0, 32'h00500093,  32'h0,      0);
        add(0, 0, 1, 32'h00100113,  1, 0, 32'h0,      0, 32'h4,      1, 32'h00100113,  32'h4,      0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,      1, 32'h8,      0, 32'h00100113,  32'h4,      0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,      0, 32'h8,      0, 32'h00100113,  32'h4,      0);
        add(0, 0, 1, 32'h00200193,  0, 0, 32'h0,      0, 32'h8,      1, 32'h00200193,  32'h8,      0);
        // backpressure in HOLD for 5 cycles; stray gnt/rvalid ignored
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,      0, 32'h8,      1, 32'h00200193,  32'h8,      0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,      0, 32'h8,      1, 32'h00200193,  32'h8,      0);
        add(0, 0, 1, 32'hFFFFFFFF,  0, 0, 32'h0,      0, 32'h8,      1, 32'h00200193,  32'h8,      0);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,      0, 32'h8,      1, 32'h00200193,  32'h8,      0);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,      0, 32'h8,      1, 32'h00200193,  32'h8,      0);
        // redirect in HOLD with simultaneous ready: 0x40, not 0xC
        add(0, 0, 0, 32'h0,         1, 1, 32'h40,     1, 32'h40,     0, 32'h00200193,  32'h8,      0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,      0, 32'h40,     0, 32'h00200193,  32'h8,      0);
        // redirect in WAIT, stale DEADBEEF drained
        add(0, 0, 0, 32'h0,         0, 1, 32'h100,    0, 32'h100,    0, 32'h00200193,  32'h8,      0);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,      0, 32'h100,    0, 32'h00200193,  32'h8,      0);
        add(0, 0, 1, 32'hDEADBEEF,  0, 0, 32'h0,      1, 32'h100,    0, 32'h00200193,  32'h8,      0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,      0, 32'h100,    0, 32'h00200193,  32'h8,      0);
        add(0, 0, 1, 32'h00000033,  0, 0, 32'h0,      0, 32'h100,    1, 32'h00000033,  32'h100,    0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,      1, 32'h104,    0, 32'h00000033,  32'h100,    0);
        // redirect in REQ coinciding with gnt -> drain
        add(0, 1, 0, 32'h0,         0, 1, 32'h200,    0, 32'h200,    0, 32'h00000033,  32'h100,    0);
        add(0, 0, 1, 32'h11111111,  0, 0, 32'h0,      1, 32'h200,    0, 32'h00000033,  32'h100,    0);
        // redirect in WAIT with simultaneous rvalid -> straight to REQ
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,      0, 32'h200,    0, 32'h00000033,  32'h100,    0);
        add(0, 0, 1, 32'hBADBADBB,  0, 1, 32'h300,    1, 32'h300,    0, 32'h00000033,  32'h100,    0);
        // redirect in REQ without gnt
        add(0, 0, 0, 32'h0,         0, 1, 32'h400,    1, 32'h400,    0, 32'h00000033,  32'h100,    0);
        // rst mid-WAIT with a response arriving, then stale rvalid ignored
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,      0, 32'h400,    0, 32'h00000033,  32'h100,    0);
        add(1, 0, 1, 32'h55555555,  0, 0, 32'h0,      0, 32'h0,      0, NOP,           32'h0,      0);
        add(0, 0, 1, 32'h66666666,  0, 0, 32'h0,      1, 32'h0,      0, NOP,           32'h0,      0);
        add(0, 0, 1, 32'h77777777,  0, 0, 32'h0,      1, 32'h0,      0, NOP,           32'h0,      0);
        // misaligned redirect: sticky fault, inputs ignored until rst
        add(0, 0, 0, 32'h0,         0, 1, 32'h102,    0, 32'h102,    0, NOP,           32'h0,      1);
        add(0, 1, 1, 32'h12345678,  0, 1, 32'h500,    0, 32'h102,    0, NOP,           32'h0,      1);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,      0, 32'h102,    0, NOP,           32'h0,      1);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,      0, 32'h102,    0, NOP,           32'h0,      1);
        add(1, 0, 0, 32'h0,         0, 0, 32'h0,      0, 32'h0,      0, NOP,           32'h0,      0);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,      1, 32'h0,      0, NOP,           32'h0,      0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; gnt = vecs[i].gnt; rvalid = vecs[i].rvalid;
            rdata = vecs[i].rdata; ready = vecs[i].ready;
            redir = vecs[i].redir; rpc = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk("req",   i, {31'b0, req},   {31'b0, vecs[i].e_req});
            chk("addr",  i, addr,           vecs[i].e_addr);
            chk("valid", i, {31'b0, valid}, {31'b0, vecs[i].e_valid});
            chk("instr", i, instr,          vecs[i].e_instr);
            chk("ipc",   i, ipc,            vecs[i].e_pc);
            chk("mis",   i, {31'b0, mis},   {31'b0, vecs[i].e_mis});
        end

        // PC wrap from 0xFFFF_FFFC to 0 after one handshake
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0; redir = 1'b0;
        @(posedge clk); #1;
        chk("wrap_rst_addr", 0, w_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_req",  0, {31'b0, w_req}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("wrap_req",  1, {31'b0, w_req}, 32'h1);
        w_gnt = 1'b1;
        @(posedge clk); #1;
        w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0000_0513;
        @(posedge clk); #1;
        w_rvalid = 1'b0;
        chk("wrap_valid", 3, {31'b0, w_valid}, 32'h1);
        chk("wrap_ipc",   3, w_ipc, 32'hFFFF_FFFC);
        chk("wrap_instr", 3, w_instr, 32'h0000_0513);
        w_ready = 1'b1;
        @(posedge clk); #1;
        w_ready = 1'b0;
        chk("wrap_addr",  4, w_addr, 32'h0);
        chk("wrap_req2",  4, {31'b0, w_req}, 32'h1);
        chk("wrap_valid2",4, {31'b0, w_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
